// File: rtl/gor_debounce.sv
// Two-channel synchroniser + debouncer feeding the gor OR gate inputs a/b.
// Optional per-channel edge pulses (arise/afall/brise/bfall) under GOR_DEBOUNCE_EDGE_EN.
module gor_debounce #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic araw,
    input  logic braw,
    output logic a,
    output logic b,
    output logic busy
`ifdef GOR_DEBOUNCE_EDGE_EN
    ,
    output logic arise,
    output logic afall,
    output logic brise,
    output logic bfall
`endif
);

    localparam int unsigned NCH = 2;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        P1 = 2'd1,
        S1 = 2'd2,
        P0 = 2'd3
    } state_e;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] out_vec;
    logic [NCH-1:0] pend_d;
    logic           busy_q;
`ifdef GOR_DEBOUNCE_EDGE_EN
    logic [NCH-1:0] rise_vec;
    logic [NCH-1:0] fall_vec;
`endif

    assign raw = {braw, araw};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic                s1_q;
        logic                s2_q;
        state_e              state_q;
        state_e              state_d;
        logic [CNT_W-1:0]    cnt_q;
        logic [CNT_W-1:0]    cnt_d;
        logic                out_q;
        logic                hit_c;
`ifdef GOR_DEBOUNCE_EDGE_EN
        logic                rise_q;
        logic                fall_q;
`endif

        assign hit_c = (cnt_q == CNT_W'(DEBOUNCE));

        // Next-state: a pending state is abandoned on any reversion, no partial credit.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                S0: begin
                    if (s2_q) begin
                        state_d = P1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                P1: begin
                    if (!s2_q) begin
                        state_d = S0;
                        cnt_d   = '0;
                    end else if (hit_c) begin
                        state_d = S1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S1: begin
                    if (!s2_q) begin
                        state_d = P0;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                P0: begin
                    if (s2_q) begin
                        state_d = S1;
                        cnt_d   = '0;
                    end else if (hit_c) begin
                        state_d = S0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Two-flop synchroniser, FSM state and registered output decode.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= S0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
`ifdef GOR_DEBOUNCE_EDGE_EN
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
`endif
            end else begin
                s1_q    <= raw[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= (state_d == S1) || (state_d == P0);
`ifdef GOR_DEBOUNCE_EDGE_EN
                rise_q  <= (state_q == P1) && (state_d == S1);
                fall_q  <= (state_q == P0) && (state_d == S0);
`endif
            end
        end

        assign out_vec[i] = out_q;
        assign pend_d[i]  = (state_d == P1) || (state_d == P0);
`ifdef GOR_DEBOUNCE_EDGE_EN
        assign rise_vec[i] = rise_q;
        assign fall_vec[i] = fall_q;
`endif
    end

    // busy is registered from next-state so it never glitches across channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pend_d;
        end
    end

    assign a    = out_vec[0];
    assign b    = out_vec[1];
    assign busy = busy_q;
`ifdef GOR_DEBOUNCE_EDGE_EN
    assign arise = rise_vec[0];
    assign afall = fall_vec[0];
    assign brise = rise_vec[1];
    assign bfall = fall_vec[1];
`endif

endmodule

// File: tb/tb_gor_debounce.sv
// Scoreboard bench for gor_debounce (DEBOUNCE=4): expected {a,b,busy} change events
// are queued by the stimulus and popped by a monitor whenever the outputs change.
module tb_gor_debounce;

    logic clk;
    logic rst;
    logic araw;
    logic braw;
    logic a;
    logic b;
    logic busy;
`ifdef GOR_DEBOUNCE_EDGE_EN
    logic arise;
    logic afall;
    logic brise;
    logic bfall;
`endif

    gor_debounce #(.DEBOUNCE(4), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .araw (araw),
        .braw (braw),
        .a    (a),
        .b    (b),
        .busy (busy)
`ifdef GOR_DEBOUNCE_EDGE_EN
        ,
        .arise(arise),
        .afall(afall),
        .brise(brise),
        .bfall(bfall)
`endif
    );

    typedef struct {
        int       at;
        logic [2:0] v;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] prev = 3'b000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int at, input logic [2:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        sb.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got {a,b,busy}=%b required %b", name, cyc, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change on {a,b,busy} must match the next queued event.
    always @(posedge clk) begin
        logic [2:0] cur;
        exp_t       e;
        #1;
        cur = {a, b, busy};
        if (cur !== prev) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got %b required no change", cyc, cur);
            end else begin
                e = sb.pop_front();
                if (e.at != cyc || e.v !== cur) begin
                    miscompares++;
                    $display("FAIL event cyc=%0d got %b required cyc=%0d val=%b",
                             cyc, cur, e.at, e.v);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int n;
        rst  = 1'b1;
        araw = 1'b1;
        braw = 1'b1;

        // Reset held with inputs high: outputs stay low.
        for (int k = 0; k < 3; k++) begin
            step(1);
            #1 chk("reset_hold", {a, b, busy}, 3'b000);
        end
        step(1);
        n = cyc; rst = 1'b0;
        push(n + 3, 3'b001); push(n + 7, 3'b110);
        step(14);

        // Both fall together.
        n = cyc; araw = 1'b0; braw = 1'b0;
        push(n + 3, 3'b111); push(n + 7, 3'b000);
        step(14);

        // Clean rise then fall on a.
        n = cyc; araw = 1'b1;
        push(n + 3, 3'b001); push(n + 7, 3'b100);
        step(14);
        n = cyc; araw = 1'b0;
        push(n + 3, 3'b101); push(n + 7, 3'b000);
        step(14);

        // 4-cycle glitch rejected.
        n = cyc; araw = 1'b1;
        push(n + 3, 3'b001); push(n + 7, 3'b000);
        step(4); araw = 1'b0;
        step(14);

        // 5-cycle pulse (exact minimum) accepted, then released.
        n = cyc; araw = 1'b1;
        push(n + 3, 3'b001); push(n + 7, 3'b100);
        push(n + 8, 3'b101); push(n + 12, 3'b000);
        step(5); araw = 1'b0;
        step(16);

        // Bounce 1,0,1,0,1 then hold.
        n = cyc;
        push(n + 3, 3'b001); push(n + 4, 3'b000);
        push(n + 5, 3'b001); push(n + 6, 3'b000);
        push(n + 7, 3'b001); push(n + 11, 3'b100);
        araw = 1'b1; step(1);
        araw = 1'b0; step(1);
        araw = 1'b1; step(1);
        araw = 1'b0; step(1);
        araw = 1'b1;
        step(14);
        n = cyc; araw = 1'b0;
        push(n + 3, 3'b101); push(n + 7, 3'b000);
        step(14);

        // Parallel rise.
        n = cyc; araw = 1'b1; braw = 1'b1;
        push(n + 3, 3'b001); push(n + 7, 3'b110);
        step(14);
        n = cyc; araw = 1'b0; braw = 1'b0;
        push(n + 3, 3'b111); push(n + 7, 3'b000);
        step(14);

        // Staggered by 2 cycles.
        n = cyc; araw = 1'b1;
        push(n + 3, 3'b001); push(n + 7, 3'b101); push(n + 9, 3'b110);
        step(2); braw = 1'b1;
        step(14);
        n = cyc; araw = 1'b0; braw = 1'b0;
        push(n + 3, 3'b111); push(n + 7, 3'b000);
        step(14);

        // Mid-debounce reset at cnt=3: immediate clear, then restart from S0.
        n = cyc; araw = 1'b1;
        push(n + 3, 3'b001); push(n + 6, 3'b000);
        step(5);
        rst = 1'b1;
        #1 chk("async_reset", {a, b, busy}, 3'b000);
        step(2);
        #1 chk("reset_abort", {a, b, busy}, 3'b000);
        step(1);
        n = cyc; rst = 1'b0;
        push(n + 3, 3'b001); push(n + 7, 3'b100);
        step(6);
        #1 chk("restart_not_early", {a, b, busy}, 3'b001);
        step(8);
        n = cyc; araw = 1'b0;
        push(n + 3, 3'b101); push(n + 7, 3'b000);
        step(20);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got %0d outstanding required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
